// File: rtl/clk_meas.sv
// clk_meas: period and high-time meter for a slow input, counted in clk_in cycles.
// Define CLK_MEAS_CONT_EN for continuous back-to-back measurement.
module clk_meas #(
  parameter int WIDTH       = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_t;

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       hcnt;
  logic                   ld;
  logic                   inc;
  logic                   upd;
  logic                   sat;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign busy = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else if (en) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  always_comb begin
    state_n = state;
    ld      = 1'b0;
    inc     = 1'b0;
    upd     = 1'b0;
    sat     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = ARM;
      end
      ARM: begin
        if (rise) begin
          ld      = 1'b1;
          state_n = MEAS;
        end
      end
      MEAS: begin
        if (rise) begin
          upd = 1'b1;
`ifdef CLK_MEAS_CONT_EN
          // closing edge opens the next window
          ld  = 1'b1;
`else
          state_n = IDLE;
`endif
        end else if (cnt == MAXV) begin
          sat = 1'b1;
`ifdef CLK_MEAS_CONT_EN
          state_n = ARM;
`else
          state_n = IDLE;
`endif
        end else begin
          inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= en & (upd | sat);
      if (en) begin
        state <= state_n;
        if (ld) begin
          cnt  <= ONE;
          hcnt <= ONE;
        end else if (inc) begin
          cnt  <= cnt + ONE;
          hcnt <= hcnt + WIDTH'(s);
        end
        if (upd) begin
          period    <= cnt;
          high_time <= hcnt;
          ovf       <= 1'b0;
        end else if (sat) begin
          period    <= MAXV;
          high_time <= hcnt;
          ovf       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_meas.sv
// Bench for clk_meas: scenario table, directed corners and a random run
// checked each cycle against a window-based reference model.
module tb_clk_meas;

  localparam int W  = 28;
  localparam int SS = 2;
  localparam longint MAXW = (longint'(1) << W) - 1;

  logic         clk_in = 1'b0;
  logic         rst;
  logic         en;
  logic         sig_in;
  logic         start;
  logic         busy;
  logic         done;
  logic         ovf;
  logic [W-1:0] period;
  logic [W-1:0] high_time;

  logic         start4;
  logic         sig4;
  logic         busy4;
  logic         done4;
  logic         ovf4;
  logic [3:0]   period4;
  logic [3:0]   high4;

  int vecs = 0;
  int errs = 0;

  clk_meas #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .sig_in   (sig_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .period   (period),
    .high_time(high_time),
    .ovf      (ovf)
  );

  clk_meas #(.WIDTH(4), .SYNC_STAGES(SS)) dut4 (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .sig_in   (sig4),
    .start    (start4),
    .busy     (busy4),
    .done     (done4),
    .period   (period4),
    .high_time(high4),
    .ovf      (ovf4)
  );

  always #5 clk_in = ~clk_in;

  // reference model: s is sig_in delayed SS enabled cycles,
  // win holds s for every cycle since t0
  typedef enum {M_IDLE, M_ARM, M_MEAS} mst_t;
  mst_t   ms = M_IDLE;
  bit     dq[$];
  bit     m_sd;
  bit     win[$];
  bit     m_done;
  bit     m_ovf;
  longint m_per;
  longint m_high;

  function automatic longint ones();
    longint c = 0;
    foreach (win[i]) c += longint'(win[i]);
    return c;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit st, input bit sg);
    bit sc;
    bit rs;
    if (r) begin
      ms = M_IDLE;
      dq.delete();
      for (int i = 0; i < SS; i++) dq.push_back(1'b0);
      m_sd = 0; win.delete();
      m_done = 0; m_ovf = 0; m_per = 0; m_high = 0;
      return;
    end
    m_done = 0;
    if (!e) return;
    sc   = dq[0];
    rs   = sc & !m_sd;
    m_sd = sc;
    void'(dq.pop_front());
    dq.push_back(sg);
    case (ms)
      M_IDLE: if (st) ms = M_ARM;
      M_ARM: if (rs) begin
        ms = M_MEAS;
        win.delete();
        win.push_back(sc);
      end
      M_MEAS: begin
        if (rs) begin
          m_per = win.size(); m_high = ones();
          m_ovf = 0; m_done = 1;
`ifdef CLK_MEAS_CONT_EN
          win.delete();
          win.push_back(sc);
`else
          ms = M_IDLE;
`endif
        end else if (longint'(win.size()) == MAXW) begin
          m_per = MAXW; m_high = ones();
          m_ovf = 1; m_done = 1;
`ifdef CLK_MEAS_CONT_EN
          ms = M_ARM;
`else
          ms = M_IDLE;
`endif
        end else begin
          win.push_back(sc);
        end
      end
      default: ms = M_IDLE;
    endcase
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  int gen_n = 10;
  int gen_h = 5;
  int gen_ph = 0;
  bit rnd_sig = 0;

  task automatic cyc();
    @(posedge clk_in);
    #1;
    model_step(rst, en, start, sig_in);
    check("model", {busy, done, ovf, period, high_time},
          {(ms != M_IDLE), m_done, m_ovf, m_per[W-1:0], m_high[W-1:0]});
    if (en) gen_ph = (gen_ph + 1) % gen_n;
    sig_in = rnd_sig ? 1'($urandom % 2) : (gen_ph < gen_h);
  endtask

  task automatic set_wave(input int n, input int h);
    gen_n = n; gen_h = h; gen_ph = 0;
    sig_in = (gen_ph < gen_h);
  endtask

  typedef struct {
    int n;
    int h;
    int gap;
    bit rst_first;
    int exp_per;
    int exp_high;
  } scen_t;

  scen_t tbl[6];

  task automatic run_scen(input scen_t sc, input string nm);
    bit got;
    bit do_rst;
    got = 0;
    do_rst = sc.rst_first;
`ifdef CLK_MEAS_CONT_EN
    do_rst = 1;
`endif
    en = 1;
    if (do_rst) begin
      rst = 1; cyc(); rst = 0;
    end
    set_wave(sc.n, sc.h);
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 200; i++) begin
      en = !(sc.gap > 0 && i >= 6 && i < 6 + sc.gap);
      cyc();
      if (!en) check({nm, "_done_gap"}, done, 0);
      if (done) begin
        got = 1;
        break;
      end
    end
    en = 1;
    check({nm, "_seen"}, got, 1);
    check({nm, "_period"}, period, sc.exp_per);
    check({nm, "_high"}, high_time, sc.exp_high);
    check({nm, "_ovf"}, ovf, 0);
`ifndef CLK_MEAS_CONT_EN
    check({nm, "_busy"}, busy, 0);
`endif
  endtask

  initial begin
    rst = 1; en = 1; start = 0; sig_in = 0;
    start4 = 0; sig4 = 0;

    tbl[0] = '{n: 10, h: 5, gap: 0, rst_first: 1, exp_per: 10, exp_high: 5};
    tbl[1] = '{n: 7,  h: 3, gap: 0, rst_first: 1, exp_per: 7,  exp_high: 3};
    tbl[2] = '{n: 7,  h: 3, gap: 0, rst_first: 0, exp_per: 7,  exp_high: 3};
    tbl[3] = '{n: 10, h: 5, gap: 6, rst_first: 0, exp_per: 10, exp_high: 5};
    tbl[4] = '{n: 12, h: 1, gap: 0, rst_first: 0, exp_per: 12, exp_high: 1};
    tbl[5] = '{n: 3,  h: 2, gap: 0, rst_first: 1, exp_per: 3,  exp_high: 2};

    cyc();
    cyc();
    check("rst_state", {busy, done, ovf, period, high_time}, 0);
    rst = 0;

    foreach (tbl[i]) run_scen(tbl[i], $sformatf("scen%0d", i));

    // reset in the middle of a measurement
    set_wave(10, 5);
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 8; i++) cyc();
    check("mid_busy", busy, 1);
    rst = 1; cyc(); rst = 0;
    check("mid_rst", {busy, done, ovf, period, high_time}, 0);
    run_scen('{n: 10, h: 5, gap: 0, rst_first: 0, exp_per: 10, exp_high: 5}, "after_rst");

    // saturation on the narrow instance
    begin
      bit got4;
      got4 = 0;
      rst = 1; cyc(); rst = 0;
      start4 = 1; cyc(); start4 = 0;
      sig4 = 1;
      for (int i = 0; i < 60; i++) begin
        cyc();
        if (done4) begin
          got4 = 1;
          break;
        end
      end
      check("ovf4_seen", got4, 1);
      check("ovf4_flag", ovf4, 1);
      check("ovf4_period", period4, 15);
      check("ovf4_high", high4, 15);
`ifndef CLK_MEAS_CONT_EN
      check("ovf4_busy", busy4, 0);
`endif
      cyc();
      check("ovf4_pulse", done4, 0);
      sig4 = 0;
    end

`ifdef CLK_MEAS_CONT_EN
    begin
      int gapc;
      bit got;
      rst = 1; cyc(); rst = 0;
      set_wave(8, 4);
      start = 1; cyc(); start = 0;
      got = 0;
      for (int i = 0; i < 40; i++) begin
        cyc();
        if (done) begin
          got = 1;
          break;
        end
      end
      check("cont_first", got, 1);
      for (int k = 0; k < 4; k++) begin
        gapc = 0;
        for (int i = 0; i < 20; i++) begin
          cyc();
          gapc++;
          check("cont_busy", busy, 1);
          if (done) break;
        end
        check("cont_spacing", gapc, 8);
        check("cont_period", period, 8);
        check("cont_high", high_time, 4);
      end
    end
`endif

    // random run against the model
    rst = 1; cyc(); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        gen_n  = $urandom_range(24, 2);
        gen_h  = $urandom_range(gen_n - 1, 1);
        gen_ph = gen_ph % gen_n;
        rnd_sig = ($urandom % 4 == 0);
      end
      rst   = ($urandom % 300 == 0);
      en    = ($urandom % 8 != 0);
      start = ($urandom % 12 == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/clk_meas.md
Name: clk_meas

Overview:
- Measures the period and high time of a slow periodic input, such as the 1 Hz CPU clock produced by the board clock divider.
- The input is sampled in the fast clk_in domain, and results are reported as counts of clk_in cycles.
- Used for self-test of the divided clock, and as a debug readout on the board.

Parameters:
WIDTH, 28, width of the period and high-time counters and result registers
SYNC_STAGES, 2, number of flip-flops in the sig_in synchronizer (minimum 2)

Ports:
clk_in  input  1  system clock; all logic is on its rising edge
rst  input  1  synchronous, active-high reset
en  input  1  clock enable; when low, all state, counters and synchronizer hold
sig_in  input  1  asynchronous signal to be measured
start  input  1  request one measurement; sampled only in IDLE with en=1
busy  output  1  high in ARM and MEAS states
done  output  1  one-cycle pulse when results update
period  output  WIDTH  clk_in cycles between two consecutive rising edges of sig_in
high_time  output  WIDTH  clk_in cycles sig_in was high within that period
ovf  output  1  last measurement overflowed; results are saturated

Behaviour:
- Reset: FSM goes to IDLE; synchronizer and edge register are cleared to 0; busy=0, done=0, period=0, high_time=0, ovf=0. This applies equally in the middle of a measurement.
- Synchronizer: sig_in passes through SYNC_STAGES flops to give s.
- Edge detect: the previous value of s is held in s_d. A rising edge is rise = s & ~s_d. Latency from a sig_in transition to rise is SYNC_STAGES cycles.
- All registers except rst handling advance only when en=1. When en=0, done is forced to 0 and everything else holds.
- FSM IDLE:
  - busy=0.
  - start=1 moves to ARM.
  - start is ignored in every other state.
- FSM ARM:
  - Waits for rise.
  - On the rise cycle (t0): cnt<=1; hcnt<=1; go to MEAS.
- FSM MEAS, each cycle:
  - If rise (t1): period<=cnt, high_time<=hcnt, ovf<=0, done<=1, then go to IDLE.
  - Otherwise: cnt<=cnt+1; hcnt<=hcnt+s.
  - Result: period = t1-t0, and high_time = number of cycles in [t0,t1) with s=1.
- Overflow:
  - If cnt is all ones and no rise occurs, go to IDLE with period=all ones, high_time=hcnt, ovf=1, done=1.
  - cnt never wraps.
- start and rise in the same IDLE cycle: go to ARM only. That edge is not used as t0.
- A glitch on sig_in shorter than one clk_in cycle may be missed. No filtering is applied.
- Outputs are registered, and period, high_time and ovf hold until the next done.

Optional Feature:
- Macro: CLK_MEAS_CONT_EN.
- Defined (continuous mode):
  - On a rise in MEAS, results update and done pulses as normal, but the FSM stays in MEAS with cnt<=1 and hcnt<=1. The closing edge therefore becomes t0 of the next measurement, and every period is reported back to back.
  - After an overflow the FSM goes to ARM, not IDLE.
  - rst is the only way to return to IDLE.
- Undefined: single-shot behaviour exactly as described above.

Test Plan:
- Source: sig_in driven as a divided clock with N=10 (5 cycles high, 5 low), en=1, one start pulse. Required response: one done pulse; period=10; high_time=5; ovf=0; busy falls in the same cycle done rises.
- Source: N=7, 3 cycles high, 4 low. Required response: period=7, high_time=3. A second start gives identical results.
- Source: WIDTH=4, sig_in held high after its first rising edge. Required response: done, ovf=1, period=15.
- Source: N=10, with en held low for 6 cycles during MEAS. Required response: period=10 counts only enabled cycles, and done stays low while en=0.
- Source: rst asserted for 1 cycle in MEAS, then start reissued. Required response: all outputs 0 after reset, and the next measurement reads period=10.
- Source: CLK_MEAS_CONT_EN defined, N=8, 4 cycles high. Required response: done every 8 cycles, each with period=8 and high_time=4; busy stays 1.
